// File: rtl/tsu_pkg.sv
// rtl/tsu_pkg.sv - shared state encoding and size defaults for the timestamp queue
package tsu_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int TS_W_DEF  = 64;
  localparam int INFOR_W   = 32;
  localparam int ENTRY_W   = TS_W_DEF + INFOR_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RES = 2'd1,
    S_COMMIT   = 2'd2
  } tsu_state_t;

endpackage

// File: rtl/tsu_queue_ram.sv
// rtl/tsu_queue_ram.sv - DEPTH x WIDTH entry storage, synchronous write, asynchronous read
module tsu_queue_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tsu_queue_ctrl.sv
// rtl/tsu_queue_ctrl.sv - PTP timestamp capture FSM and FWFT entry queue
// Optional drop counter enabled by macro TSU_QUEUE_OVF_CNT_EN.
module tsu_queue_ctrl
  import tsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     int_valid,
  input  logic                     int_sop,
  input  logic                     int_eop,
  input  logic [TS_W-1:0]          rtc_time,
  input  logic                     ptp_found,
  input  logic [INFOR_W-1:0]       ptp_infor,
  input  logic                     q_pop,
  input  logic                     q_flush,
  output logic [TS_W+INFOR_W-1:0]  q_data,
  output logic                     q_empty,
  output logic                     q_full,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic [7:0]               q_ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + INFOR_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  tsu_state_t      state;
  logic [TS_W-1:0] ts_lat;
  logic            found_q;
  logic            found_rise;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic            commit;
  logic            pop_ok;
  logic            wr_en;
  logic [EW-1:0]   ram_rdata;

  assign found_rise = ptp_found && !found_q;

  // A new SOP always restarts capture, even while COMMIT writes the previous latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ts_lat  <= '0;
      found_q <= 1'b0;
    end else begin
      found_q <= ptp_found;
      if (int_valid && int_sop) begin
        ts_lat <= rtc_time;
        state  <= S_WAIT_RES;
      end else begin
        case (state)
          S_WAIT_RES: begin
            if (found_rise)                state <= S_COMMIT;
            else if (int_valid && int_eop) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign commit  = (state == S_COMMIT);
  assign q_empty = (level == '0);
  assign q_full  = (level == FULL_LVL);
  assign q_level = level;
  assign pop_ok  = q_pop && !q_empty && !q_flush;
  assign wr_en   = commit && !q_flush && (!q_full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (q_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef TSU_QUEUE_OVF_CNT_EN
  logic       drop;
  logic [7:0] ovf_cnt;

  assign drop = commit && !q_flush && q_full && !pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_cnt <= '0;
    else if (q_flush)                 ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
  end

  assign q_ovf_cnt = ovf_cnt;
`else
  assign q_ovf_cnt = '0;
`endif

  tsu_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({ts_lat, ptp_infor}),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  // Storage is not reset, so the empty head is forced to zero.
  assign q_data = q_empty ? '0 : ram_rdata;

endmodule
